decipher_stream: RTL and testbench
==================================

DECIPHER_STREAM -- requirements
Module: decipher_stream

Interface
REQ-001 Parameter SEED, default 8'h00: LFSR load value after reset, resync and frame end.
REQ-002 Parameter KEY, default 8'b10011101: fixed key byte XORed into the keystream.
REQ-003 Parameter FRAME_LEN, default 16: bytes per frame; legal range 1..255.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 resync  input  1: synchronous restart of the keystream; one-cycle pulse.
REQ-007 in_valid  input  1: ciphertext byte present on in_data.
REQ-008 in_data  input  8: ciphertext byte.
REQ-009 in_ready  output  1: block can accept a byte this cycle.
REQ-010 out_valid  output  1: plaintext byte present on out_data.
REQ-011 out_data  output  8: plaintext byte.
REQ-012 out_ready  input  1: downstream accepts out_data this cycle.
REQ-013 frame_done  output  1: one-cycle pulse when the last byte of a frame is accepted.
REQ-014 busy  output  1: high in state RUN.

Function
REQ-015 LFSR: 8-bit register Q[8:1] with Q[k] mapped to bit k-1; per step, Q[1] <= XNOR(Q[1],Q[8]) and Q[k] <= Q[k-1] for k=2..8.
REQ-016 Keystream byte K SHALL be Q XOR KEY, taken from the LFSR value before the step.
REQ-017 Accept occurs when in_valid && in_ready.
REQ-018 in_ready SHALL be (!out_valid || out_ready) && !resync, combinationally.
REQ-019 On accept: out_data <= in_data XOR K, out_valid <= 1 next cycle, and the LFSR steps once. Latency is 1 cycle.
REQ-020 out_valid SHALL clear on a cycle with out_ready && !accept, and SHALL stay high with out_data stable while !out_ready.
REQ-021 A simultaneous accept and out_ready SHALL give full throughput of 1 byte/cycle with no bubble.
REQ-022 The LFSR SHALL NOT step on any cycle without an accept.
REQ-023 FSM states: IDLE and RUN.
  - IDLE -> RUN on the first accept of a frame.
  - RUN -> IDLE on the accept that brings the 8-bit byte count to FRAME_LEN.
  - If FRAME_LEN=1, the FSM SHALL remain in IDLE and every accept SHALL be a frame end.
REQ-024 Byte count SHALL increment on each accept and clear to 0 on frame end.
REQ-025 Frame end, same edge as the last accept: the LFSR loads SEED instead of stepping, and frame_done=1 for that one following cycle.
REQ-026 resync SHALL have priority over everything, on its edge:
  - LFSR <= SEED; count <= 0; state <= IDLE.
  - out_valid <= 0, and any pending byte is discarded.
  - frame_done <= 0.
REQ-027 Decryption is the exact inverse of an encryptor that uses the same SEED, KEY, step rule and framing: plaintext = ciphertext XOR (Q XOR KEY).

Reset
REQ-028 While reset=0: Q=SEED, count=0, state=IDLE, out_valid=0, out_data=8'h00, frame_done=0, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; the first accept after release uses K = SEED XOR KEY.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release when resync=0.

Verification
REQ-031 Reset, then 5 consecutive accepts of in_data=00 with out_ready=1 -> out_data sequence 9D,9C,9F,98,97 (Q=00,01,02,05,0A).
REQ-032 Send ciphertext 9D^41 = DC as the first byte after reset -> out_data=41, out_valid one cycle after accept.
REQ-033 Hold out_ready=0 after one accept -> in_ready=0, out_data stable, LFSR unchanged; release -> stream continues with K=9C.
REQ-034 Send FRAME_LEN=16 bytes back-to-back -> frame_done pulses once after the 16th accept, busy falls, and the 17th byte with in_data=00 gives 9D.
REQ-035 Pulse resync after 3 accepts while out_valid=1 -> out_valid=0 next cycle; the next accept of 00 gives 9D.
REQ-036 Loopback test: a reference encryptor feeds 1000 random bytes with random in_valid/out_ready stalls -> output equals the original plaintext bit-exact, with no drops or duplicates.

Source files
------------

// File: rtl/decipher_stream.sv
// decipher_stream
//   Byte-serial stream decipher. Each accepted ciphertext byte is XORed with a
//   keystream byte K = Q ^ KEY, where Q is an 8-bit XNOR LFSR that steps once
//   per accepted byte. The keystream restarts from SEED at every frame end, on
//   resync and on reset. Output is a one-deep registered stage with
//   valid/ready handshaking that sustains one byte per cycle.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   resync      synchronous keystream restart; drops any pending output byte
//   in_valid    ciphertext byte present on in_data
//   in_data     ciphertext byte
//   in_ready    block can accept a byte this cycle (combinational)
//   out_valid   plaintext byte present on out_data
//   out_data    plaintext byte
//   out_ready   downstream takes out_data this cycle
//   frame_done  one-cycle pulse after the last byte of a frame is accepted
//   busy        high while a frame is in progress (state RUN)

module decipher_stream #(
  parameter logic [7:0] SEED      = 8'h00,
  parameter logic [7:0] KEY       = 8'b10011101,
  parameter int         FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resync,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Count value held while the last byte of a frame is being accepted.
  localparam logic [7:0] LastCount = 8'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] count_q, count_d;
  logic       outValid_q, outValid_d;
  logic [7:0] outData_q, outData_d;
  logic       frameDone_q, frameDone_d;

  logic       accept;
  logic       frameEnd;
  logic [7:0] lfsrStep;

  // The output register can take a new byte when it is empty or being drained
  // this cycle; resync blocks acceptance so the byte is not lost silently.
  assign in_ready = (!outValid_q || out_ready) && !resync;
  assign accept   = in_valid && in_ready;
  assign frameEnd = accept && (count_q == LastCount);

  // Q[1] is bit 0: shift toward the MSB and feed back XNOR of the end taps.
  assign lfsrStep = {lfsr_q[6:0], ~(lfsr_q[0] ^ lfsr_q[7])};

  // Next-state logic. resync overrides everything; otherwise an accept loads a
  // new plaintext byte and advances (or reloads at frame end) the keystream,
  // and a drain without a refill empties the output stage.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    count_d     = count_q;
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    frameDone_d = 1'b0;

    if (resync) begin
      state_d    = IDLE;
      lfsr_d     = SEED;
      count_d    = 8'h00;
      outValid_d = 1'b0;
    end else if (accept) begin
      outData_d  = in_data ^ lfsr_q ^ KEY;
      outValid_d = 1'b1;
      if (frameEnd) begin
        state_d     = IDLE;
        lfsr_d      = SEED;
        count_d     = 8'h00;
        frameDone_d = 1'b1;
      end else begin
        state_d = RUN;
        lfsr_d  = lfsrStep;
        count_d = count_q + 8'd1;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      count_q     <= 8'h00;
      outValid_q  <= 1'b0;
      outData_q   <= 8'h00;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      count_q     <= count_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign frame_done = frameDone_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_decipher_stream.sv
// tb_decipher_stream
//   Directed tests for decipher_stream plus a randomized loopback against a
//   reference encryptor. Inputs change and outputs are sampled 1 ns after the
//   rising clock edge.

module tb_decipher_stream;

  localparam logic [7:0] SEED = 8'h00;
  localparam logic [7:0] KEY  = 8'h9D;
  localparam int         FLEN = 16;

  logic       clk;
  logic       reset;
  logic       resync;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       frame_done;
  logic       busy;

  int total;
  int bad;

  decipher_stream #(
    .SEED     (SEED),
    .KEY      (KEY),
    .FRAME_LEN(FLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .resync    (resync),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .busy      (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference keystream step: Q[1] <= XNOR(Q[1],Q[8]), Q[k] <= Q[k-1].
  function automatic logic [7:0] lfsrModel(input logic [7:0] q);
    logic [7:0] n;
    n[0] = ~(q[0] ^ q[7]);
    for (int k = 1; k < 8; k++) n[k] = q[k-1];
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset     = 1'b0;
    resync    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    resync    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_keystream();
    logic [7:0] expSeq [5];
    expSeq = '{8'h9D, 8'h9C, 8'h9F, 8'h98, 8'h97};
    applyReset();
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== expSeq[i])
        begin bad++; $display("[TB] FAIL keystream[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, expSeq[i]); end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL keystream_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_known_plaintext();
    applyReset();
    in_valid = 1'b1;
    in_data  = 8'hDC;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL kp_latency: got out_valid=%b before edge want 0", out_valid); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h41)
      begin bad++; $display("[TB] FAIL kp_data: got v=%b d=%h want v=1 d=41", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    applyReset();
    in_valid  = 1'b1;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h9D)
      begin bad++; $display("[TB] FAIL bp_first: got v=%b d=%h want v=1 d=9D", out_valid, out_data); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h9D)
        begin bad++; $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=9D", i, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h9C)
      begin bad++; $display("[TB] FAIL bp_continue: got v=%b d=%h want v=1 d=9C", out_valid, out_data); end
  endtask

  task automatic test_frame();
    logic [7:0] q;
    logic [7:0] expByte;
    applyReset();
    q         = SEED;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    for (int i = 0; i < FLEN; i++) begin
      expByte = q ^ KEY;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== expByte)
        begin bad++; $display("[TB] FAIL frame_byte[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, expByte); end
      if (i < FLEN - 1) begin
        total++;
        if (busy !== 1'b1 || frame_done !== 1'b0)
          begin bad++; $display("[TB] FAIL frame_mid[%0d]: got busy=%b done=%b want busy=1 done=0", i, busy, frame_done); end
      end
      q = lfsrModel(q);
    end
    total++;
    if (frame_done !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("[TB] FAIL frame_end: got done=%b busy=%b want done=1 busy=0", frame_done, busy); end
    tick();
    total++;
    if (out_data !== 8'h9D || frame_done !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("[TB] FAIL frame_next: got d=%h done=%b busy=%b want d=9D done=0 busy=1", out_data, frame_done, busy); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_resync();
    applyReset();
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    tick();
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h9F)
      begin bad++; $display("[TB] FAIL resync_pre: got v=%b d=%h want v=1 d=9F", out_valid, out_data); end
    resync    = 1'b1;
    out_ready = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL resync_in_ready: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    resync    = 1'b0;
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("[TB] FAIL resync_clear: got v=%b busy=%b want v=0 busy=0", out_valid, busy); end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h9D)
      begin bad++; $display("[TB] FAIL resync_restart: got v=%b d=%h want v=1 d=9D", out_valid, out_data); end
    tick();
  endtask

  task automatic test_reset_midframe();
    applyReset();
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0)
      begin bad++; $display("[TB] FAIL midreset_clear: got v=%b d=%h busy=%b want v=0 d=00 busy=0", out_valid, out_data, busy); end
    reset = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h9D)
      begin bad++; $display("[TB] FAIL midreset_restart: got v=%b d=%h want v=1 d=9D", out_valid, out_data); end
    tick();
  endtask

  task automatic test_loopback();
    logic [7:0] plain [1000];
    logic [7:0] encQ;
    int         encCount;
    int         sent;
    int         received;
    int         cycles;
    for (int i = 0; i < 1000; i++) plain[i] = 8'($urandom);
    applyReset();
    encQ     = SEED;
    encCount = 0;
    sent     = 0;
    received = 0;
    cycles   = 0;
    while (received < 1000 && cycles < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = (sent < 1000) ? (plain[sent] ^ encQ ^ KEY) : 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== plain[received])
          begin bad++; $display("[TB] FAIL loop_byte[%0d]: got %h want %h", received, out_data, plain[received]); end
        received++;
      end
      if (in_valid && in_ready) begin
        sent++;
        encCount++;
        if (encCount == FLEN) begin
          encCount = 0;
          encQ     = SEED;
        end else begin
          encQ = lfsrModel(encQ);
        end
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (received != 1000)
      begin bad++; $display("[TB] FAIL loop_count: got %0d bytes want 1000", received); end
    tick();
    total++;
    if (out_valid !== 1'b0)
      begin bad++; $display("[TB] FAIL loop_extra: got out_valid=%b after stream want 0", out_valid); end
  endtask

  // Run all scenarios in sequence and print the summary.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_keystream();
    test_known_plaintext();
    test_backpressure();
    test_frame();
    test_resync();
    test_reset_midframe();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
